msix_vector_table: RTL and testbench
====================================

Name: msix_vector_table

Overview:
- Parametrised MSI-X capability backend: holds NUM_VECTORS table entries (lower address, upper address, data, vector control) and the Pending Bit Array (PBA).
- Sets a pending bit for each interrupt request and arbitrates round-robin among unmasked pending vectors.
- Emits one MSI-X memory-write descriptor at a time over a valid/ready handshake to the TLP generator.
- Extends the single upper-address register with full per-vector storage, 64-bit address detection per message, masking, and message generation.

Parameters:
- NUM_VECTORS, 8, number of MSI-X vectors (legal range 1..2048).
- VEC_W, $clog2(NUM_VECTORS) with minimum 1, width of the vector index.
- CFG_ADDR_W, 12, dword address width of the config access port.

Ports:
- clk  input  1  clock.
- rst_n  input  1  synchronous active-low reset.
- cfg_wr_en  input  1  dword write strobe.
- cfg_rd_en  input  1  dword read strobe.
- cfg_addr  input  CFG_ADDR_W  dword address.
- cfg_wdata  input  32  write data.
- cfg_rdata  output  32  read data, valid when cfg_rd_valid is 1.
- cfg_rd_valid  output  1  read-data qualifier, one cycle after cfg_rd_en.
- msix_enable  input  1  MSI-X Enable bit from the Message Control register.
- function_mask  input  1  Function Mask bit from the Message Control register.
- irq_req  input  NUM_VECTORS  per-vector request; a 1 in any cycle sets that vector's pending bit.
- msg_valid  output  1  message descriptor valid.
- msg_ready  input  1  downstream accepts the descriptor.
- msg_addr  output  64  {upper, lower[31:2], 2'b00}.
- msg_data  output  32  message data.
- msg_vector  output  VEC_W  vector index being sent.
- msg_is_64bit  output  1  1 when the latched upper address is non-zero.
- pending_any  output  1  OR of all pending bits.

Behaviour:
- Clock, reset and timing:
  - Single clock domain: clk.
  - rst_n is synchronous and active-low; all state updates on the rising edge of clk.
- Reset values:
  - All addresses and data: 0.
  - Every mask bit: 1.
  - Pending bits: 0.
  - Round-robin pointer: 0.
  - FSM state: IDLE.
  - msg_valid, msg_addr, msg_data, msg_vector, msg_is_64bit: 0.
  - cfg_rdata: 0; cfg_rd_valid: 0.
  - Reset asserted mid-handshake drops msg_valid at the next edge with no message counted.
- Address map (dword addresses):
  - Entry n: 4n+0 = lower address (bits [1:0] read as 0, writes to them ignored); 4n+1 = upper address; 4n+2 = data; 4n+3 = vector control (bit0 = mask, bits [31:1] read as 0).
  - PBA word k: 4*NUM_VECTORS+k, for k < ceil(NUM_VECTORS/32); read-only, unused high bits read 0.
  - Writes to the PBA or out-of-range addresses are ignored; reads of them return 0.
  - Read latency is 1 cycle; a read concurrent with a write to the same address returns the old value.
- Pending bits:
  - Set on an irq_req bit regardless of mask or enable.
  - Cleared only on a handshake (msg_valid & msg_ready) for msg_vector.
  - If irq_req for that same vector is high in the handshake cycle, the bit stays set.
- Eligible vectors: pending & ~mask & {NUM_VECTORS{msix_enable & ~function_mask}}.
- FSM:
  - IDLE: if any vector is eligible, select the first eligible index at or after the round-robin pointer (wrapping past NUM_VECTORS-1 to 0). Latch msg_addr, msg_data, msg_vector and msg_is_64bit from the current table contents. Next cycle: msg_valid=1, state SEND.
  - SEND: hold all msg_* outputs stable while msg_ready=0.
  - SEND, on handshake: msg_valid=0, pointer = msg_vector+1 (wrapping), state IDLE.
  - Minimum spacing between messages is 2 cycles.
- Once msg_valid is asserted it is never withdrawn, even if the vector is masked, msix_enable falls, or the entry is rewritten. The message carries the latched values and is cleared normally on acceptance.
- Latency: irq_req at cycle T sets pending at T+1; msg_valid is 1 at T+2, provided the vector is eligible and the FSM is idle.
- Unmasking a vector whose pending bit is set makes it eligible in the next cycle; no new request is needed.
- pending_any is registered-derived (OR of the pending register).

Test Plan:
- Program entry 2 with lower=0xFEE0_1003, upper=0, data=0x0000_0042, mask=0; pulse irq_req[2]; msg_ready=1 -> msg_valid at +2 cycles with addr=0x0000_0000_FEE0_1000, data=0x42, vector=2, is_64bit=0; PBA bit2 clears after handshake.
- Set entry 5 upper=0x0000_0001, lower=0x1000; request vector 5 -> msg_addr=0x0000_0001_0000_1000, is_64bit=1.
- With vector 3 masked, pulse irq_req[3] -> no message, PBA word0 reads 0x8. Then clear the mask -> message for vector 3 within 2 cycles and PBA reads 0.
- Assert irq_req[0,1,7] together with msg_ready=1 -> vectors sent in order 0,1,7. Then re-request 0 and 7 with the pointer at 0 -> order 0,7 (wrap-around).
- Hold msg_ready=0 for 5 cycles while writing new data to the entry being sent and asserting function_mask -> msg_* stable for all 5 cycles; on accept, the old data is delivered and no further message is sent while function_mask=1.
- Reset mid-SEND -> msg_valid=0 and all pending bits 0 next cycle; all mask bits read back as 1; a read of address 4*NUM_VECTORS+40 returns 0.

Source files
------------

// File: rtl/msix_vector_table.sv
`default_nettype none
// ============================================================================
// Module      : msix_vector_table
// Description : MSI-X table and Pending Bit Array backend. Stores per-vector
//               address, data and mask, latches requests into pending bits,
//               and round-robin arbitrates unmasked pending vectors into
//               one memory-write descriptor at a time (valid/ready).
// Revision    : 1.0 - initial release
// ============================================================================
module msix_vector_table #(
  parameter int NUM_VECTORS = 8,
  parameter int VEC_W       = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1,
  parameter int CFG_ADDR_W  = 12
) (
  input  logic                   clk,
  input  logic                   rst_n,
  // dword config access to table and PBA
  input  logic                   cfg_wr_en,
  input  logic                   cfg_rd_en,
  input  logic [CFG_ADDR_W-1:0]  cfg_addr,
  input  logic [31:0]            cfg_wdata,
  output logic [31:0]            cfg_rdata,
  output logic                   cfg_rd_valid,
  // message control bits
  input  logic                   msix_enable,
  input  logic                   function_mask,
  // interrupt requests
  input  logic [NUM_VECTORS-1:0] irq_req,
  // message descriptor to the TLP generator
  output logic                   msg_valid,
  input  logic                   msg_ready,
  output logic [63:0]            msg_addr,
  output logic [31:0]            msg_data,
  output logic [VEC_W-1:0]       msg_vector,
  output logic                   msg_is_64bit,
  output logic                   pending_any
);

  localparam int              PBA_WORDS  = (NUM_VECTORS + 31) / 32;
  localparam int              TABLE_DW   = 4 * NUM_VECTORS;
  localparam logic [31:0]     C_PBA_BASE = 32'(TABLE_DW);
  localparam logic [VEC_W:0]  C_NUM_VEC  = (VEC_W + 1)'(NUM_VECTORS);
  localparam logic [VEC_W-1:0] C_LAST_VEC = VEC_W'(NUM_VECTORS - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  // Lower address keeps only bits [31:2]; the dword-alignment bits are fixed 0.
  logic [29:0]            lower_q [NUM_VECTORS];
  logic [29:0]            lower_d [NUM_VECTORS];
  logic [31:0]            upper_q [NUM_VECTORS];
  logic [31:0]            upper_d [NUM_VECTORS];
  logic [31:0]            data_q  [NUM_VECTORS];
  logic [31:0]            data_d  [NUM_VECTORS];
  logic [NUM_VECTORS-1:0] mask_q,    mask_d;
  logic [NUM_VECTORS-1:0] pending_q, pending_d;
  logic [VEC_W-1:0]       rr_ptr_q,  rr_ptr_d;
  state_e                 state_q,   state_d;

  logic                   msg_valid_q,    msg_valid_d;
  logic [63:0]            msg_addr_q,     msg_addr_d;
  logic [31:0]            msg_data_q,     msg_data_d;
  logic [VEC_W-1:0]       msg_vector_q,   msg_vector_d;
  logic                   msg_is_64bit_q, msg_is_64bit_d;

  logic [31:0]            cfg_rdata_q,    cfg_rdata_d;
  logic                   cfg_rd_valid_q, cfg_rd_valid_d;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic [31:0]              w_addr;
  logic                     w_in_table;
  logic [VEC_W-1:0]         w_entry;
  logic [1:0]               w_field;
  logic [PBA_WORDS*32-1:0]  w_pba_pad;
  logic [NUM_VECTORS-1:0]   w_eligible;
  logic                     w_found;
  logic [VEC_W-1:0]         w_sel;
  logic                     w_handshake;

  assign w_addr      = 32'(cfg_addr);
  assign w_in_table  = (w_addr < C_PBA_BASE);
  assign w_entry     = w_addr[VEC_W+1:2];
  assign w_field     = w_addr[1:0];
  assign w_pba_pad   = (PBA_WORDS*32)'(pending_q);
  assign w_handshake = msg_valid_q & msg_ready;

  // A vector competes only when pending, unmasked and the function is enabled.
  assign w_eligible = pending_q & ~mask_q
                    & {NUM_VECTORS{msix_enable & ~function_mask}};
  assign w_found    = |w_eligible;

  // ---------------------------------------------------------------------------
  // Table writes: one field of one entry per write strobe; PBA and
  // out-of-range addresses fall through untouched.
  // ---------------------------------------------------------------------------
  always_comb begin
    lower_d = lower_q;
    upper_d = upper_q;
    data_d  = data_q;
    mask_d  = mask_q;
    if (cfg_wr_en && w_in_table) begin
      case (w_field)
        2'd0:    lower_d[w_entry] = cfg_wdata[31:2];
        2'd1:    upper_d[w_entry] = cfg_wdata;
        2'd2:    data_d[w_entry]  = cfg_wdata;
        default: mask_d[w_entry]  = cfg_wdata[0];
      endcase
    end
  end

  // Config reads: registered one cycle, sampled from pre-write state so a
  // concurrent write to the same address returns the old value.
  always_comb begin
    cfg_rd_valid_d = cfg_rd_en;
    cfg_rdata_d    = cfg_rdata_q;
    if (cfg_rd_en) begin
      cfg_rdata_d = '0;
      if (w_in_table) begin
        case (w_field)
          2'd0:    cfg_rdata_d = {lower_q[w_entry], 2'b00};
          2'd1:    cfg_rdata_d = upper_q[w_entry];
          2'd2:    cfg_rdata_d = data_q[w_entry];
          default: cfg_rdata_d = {31'b0, mask_q[w_entry]};
        endcase
      end else begin
        for (int k = 0; k < PBA_WORDS; k++) begin
          if (w_addr == 32'(TABLE_DW + k)) begin
            cfg_rdata_d = w_pba_pad[k*32 +: 32];
          end
        end
      end
    end
  end

  // Pending bits: set by any request, cleared only by acceptance of that
  // vector's message; a same-cycle request wins over the clear.
  always_comb begin
    pending_d = pending_q;
    for (int i = 0; i < NUM_VECTORS; i++) begin
      if (w_handshake && (msg_vector_q == VEC_W'(i))) begin
        pending_d[i] = 1'b0;
      end
    end
    pending_d = pending_d | irq_req;
  end

  // Round-robin pick: first eligible index at or after the pointer, wrapping.
  // Scanning from the far end lets the nearest match overwrite the others.
  always_comb begin
    logic [VEC_W:0] idx;
    idx   = '0;
    w_sel = '0;
    for (int j = NUM_VECTORS - 1; j >= 0; j--) begin
      idx = {1'b0, rr_ptr_q} + (VEC_W + 1)'(j);
      if (idx >= C_NUM_VEC) begin
        idx = idx - C_NUM_VEC;
      end
      if (w_eligible[idx[VEC_W-1:0]]) begin
        w_sel = idx[VEC_W-1:0];
      end
    end
  end

  // Message FSM: latch a descriptor in IDLE, hold it untouched in SEND until
  // accepted, then advance the pointer past the vector just sent.
  always_comb begin
    state_d        = state_q;
    msg_valid_d    = msg_valid_q;
    msg_addr_d     = msg_addr_q;
    msg_data_d     = msg_data_q;
    msg_vector_d   = msg_vector_q;
    msg_is_64bit_d = msg_is_64bit_q;
    rr_ptr_d       = rr_ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (w_found) begin
          msg_addr_d     = {upper_q[w_sel], lower_q[w_sel], 2'b00};
          msg_data_d     = data_q[w_sel];
          msg_vector_d   = w_sel;
          msg_is_64bit_d = |upper_q[w_sel];
          msg_valid_d    = 1'b1;
          state_d        = ST_SEND;
        end
      end
      ST_SEND: begin
        if (msg_ready) begin
          msg_valid_d = 1'b0;
          rr_ptr_d    = (msg_vector_q == C_LAST_VEC) ? '0
                                                     : msg_vector_q + VEC_W'(1);
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        msg_valid_d = 1'b0;
      end
    endcase
  end

  // State registers with synchronous active-low reset; masks come up set.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lower_q        <= '{default: '0};
      upper_q        <= '{default: '0};
      data_q         <= '{default: '0};
      mask_q         <= '1;
      pending_q      <= '0;
      rr_ptr_q       <= '0;
      state_q        <= ST_IDLE;
      msg_valid_q    <= 1'b0;
      msg_addr_q     <= '0;
      msg_data_q     <= '0;
      msg_vector_q   <= '0;
      msg_is_64bit_q <= 1'b0;
      cfg_rdata_q    <= '0;
      cfg_rd_valid_q <= 1'b0;
    end else begin
      lower_q        <= lower_d;
      upper_q        <= upper_d;
      data_q         <= data_d;
      mask_q         <= mask_d;
      pending_q      <= pending_d;
      rr_ptr_q       <= rr_ptr_d;
      state_q        <= state_d;
      msg_valid_q    <= msg_valid_d;
      msg_addr_q     <= msg_addr_d;
      msg_data_q     <= msg_data_d;
      msg_vector_q   <= msg_vector_d;
      msg_is_64bit_q <= msg_is_64bit_d;
      cfg_rdata_q    <= cfg_rdata_d;
      cfg_rd_valid_q <= cfg_rd_valid_d;
    end
  end

  assign msg_valid    = msg_valid_q;
  assign msg_addr     = msg_addr_q;
  assign msg_data     = msg_data_q;
  assign msg_vector   = msg_vector_q;
  assign msg_is_64bit = msg_is_64bit_q;
  assign cfg_rdata    = cfg_rdata_q;
  assign cfg_rd_valid = cfg_rd_valid_q;
  assign pending_any  = |pending_q;

endmodule
`default_nettype wire

// File: tb/tb_msix_vector_table.sv
`default_nettype none
// ============================================================================
// Module      : tb_msix_vector_table
// Description : Directed bench for msix_vector_table with a transaction-level
//               reference model compared every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_msix_vector_table;

  localparam int NV = 8;
  localparam int VW = 3;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_wr_en, cfg_rd_en;
  logic [AW-1:0] cfg_addr;
  logic [31:0]   cfg_wdata;
  logic [31:0]   cfg_rdata;
  logic          cfg_rd_valid;
  logic          msix_enable, function_mask;
  logic [NV-1:0] irq_req;
  logic          msg_valid, msg_ready;
  logic [63:0]   msg_addr;
  logic [31:0]   msg_data;
  logic [VW-1:0] msg_vector;
  logic          msg_is_64bit;
  logic          pending_any;

  msix_vector_table #(.NUM_VECTORS(NV), .VEC_W(VW), .CFG_ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_wr_en(cfg_wr_en), .cfg_rd_en(cfg_rd_en), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata), .cfg_rd_valid(cfg_rd_valid),
    .msix_enable(msix_enable), .function_mask(function_mask),
    .irq_req(irq_req),
    .msg_valid(msg_valid), .msg_ready(msg_ready), .msg_addr(msg_addr),
    .msg_data(msg_data), .msg_vector(msg_vector), .msg_is_64bit(msg_is_64bit),
    .pending_any(pending_any)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int hs_q[$];

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: table contents, pending set, one in-flight message.
  // ---------------------------------------------------------------------------
  logic [31:0]   m_lower [NV];
  logic [31:0]   m_upper [NV];
  logic [31:0]   m_data  [NV];
  logic [NV-1:0] m_mask = '1;
  logic [NV-1:0] m_pend = '0;
  int            m_ptr = 0;
  bit            m_valid = 0;
  logic [63:0]   m_addr = '0;
  logic [31:0]   m_mdata = '0;
  int            m_vec = 0;
  bit            m_is64 = 0;
  bit            m_rd_valid = 0;
  logic [31:0]   m_rdata = '0;

  function automatic logic [31:0] model_read(int a);
    if (a < 4*NV) begin
      case (a % 4)
        0:       return m_lower[a/4];
        1:       return m_upper[a/4];
        2:       return m_data[a/4];
        default: return {31'b0, m_mask[a/4]};
      endcase
    end
    if (a < 4*NV + (NV+31)/32) return 32'(m_pend >> (32*(a - 4*NV)));
    return 32'h0;
  endfunction

  always @(posedge clk) begin : model
    logic [NV-1:0] old_pend;
    int  v;
    bit  found;
    if (!rst_n) begin
      for (int i = 0; i < NV; i++) begin
        m_lower[i] = '0; m_upper[i] = '0; m_data[i] = '0;
      end
      m_mask = '1; m_pend = '0; m_ptr = 0; m_valid = 0;
      m_addr = '0; m_mdata = '0; m_vec = 0; m_is64 = 0;
      m_rd_valid = 0; m_rdata = '0;
    end else begin
      old_pend = m_pend;
      if (cfg_rd_en) m_rdata = model_read(int'(cfg_addr));
      m_rd_valid = cfg_rd_en;
      if (m_valid) begin
        if (msg_ready) begin
          m_valid = 0;
          m_pend[m_vec] = 1'b0;
          m_ptr = (m_vec + 1) % NV;
        end
      end else if (msix_enable && !function_mask) begin
        found = 0;
        for (int k = 0; k < NV; k++) begin
          v = (m_ptr + k) % NV;
          if (!found && old_pend[v] && !m_mask[v]) begin
            found   = 1;
            m_valid = 1;
            m_vec   = v;
            m_addr  = {m_upper[v], m_lower[v]};
            m_mdata = m_data[v];
            m_is64  = (m_upper[v] != 0);
          end
        end
      end
      m_pend = m_pend | irq_req;
      if (cfg_wr_en && int'(cfg_addr) < 4*NV) begin
        v = int'(cfg_addr) / 4;
        case (int'(cfg_addr) % 4)
          0:       m_lower[v] = {cfg_wdata[31:2], 2'b00};
          1:       m_upper[v] = cfg_wdata;
          2:       m_data[v]  = cfg_wdata;
          default: m_mask[v]  = cfg_wdata[0];
        endcase
      end
    end
  end

  // Per-cycle comparison against the model, plus log of accepted vectors.
  always @(negedge clk) begin
    check("msg_valid", 64'(msg_valid), 64'(m_valid));
    if (m_valid && msg_valid) begin
      check("msg_addr",   msg_addr, m_addr);
      check("msg_data",   64'(msg_data), 64'(m_mdata));
      check("msg_vector", 64'(msg_vector), 64'(m_vec));
      check("msg_is_64bit", 64'(msg_is_64bit), 64'(m_is64));
    end
    check("pending_any", 64'(pending_any), 64'(|m_pend));
    check("cfg_rd_valid", 64'(cfg_rd_valid), 64'(m_rd_valid));
    if (m_rd_valid) check("cfg_rdata", 64'(cfg_rdata), 64'(m_rdata));
    if (msg_valid && msg_ready && rst_n) hs_q.push_back(int'(msg_vector));
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(int a, logic [31:0] d);
    cfg_wr_en = 1'b1; cfg_addr = AW'(a); cfg_wdata = d;
    tick();
    cfg_wr_en = 1'b0;
  endtask

  task automatic cfg_read(string name, int a, logic [31:0] exp);
    cfg_rd_en = 1'b1; cfg_addr = AW'(a);
    tick();
    cfg_rd_en = 1'b0;
    check(name, 64'(cfg_rdata), 64'(exp));
  endtask

  task automatic pulse_irq(logic [NV-1:0] v);
    irq_req = v;
    tick();
    irq_req = '0;
  endtask

  task automatic wait_valid(string name, int max);
    int n;
    n = 0;
    while (!msg_valid && n < max) begin
      tick();
      n++;
    end
    check(name, 64'(msg_valid), 64'd1);
  endtask

  function automatic int hs_at(int i);
    return (hs_q.size() > i) ? hs_q[i] : -1;
  endfunction

  initial begin
    rst_n = 1'b0; cfg_wr_en = 0; cfg_rd_en = 0; cfg_addr = '0; cfg_wdata = '0;
    msix_enable = 0; function_mask = 0; irq_req = '0; msg_ready = 0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Reset state
    check("rst_valid",   64'(msg_valid), 64'd0);
    check("rst_addr",    msg_addr, 64'd0);
    check("rst_data",    64'(msg_data), 64'd0);
    check("rst_vector",  64'(msg_vector), 64'd0);
    check("rst_pending", 64'(pending_any), 64'd0);
    cfg_read("rst_mask2", 11, 32'h1);

    // Basic 32-bit message on vector 2
    msix_enable = 1; function_mask = 0; msg_ready = 1;
    cfg_write(8, 32'hFEE0_1003); cfg_write(9, 0);
    cfg_write(10, 32'h42);       cfg_write(11, 0);
    cfg_read("t1_lower", 8, 32'hFEE0_1000);
    pulse_irq(8'h04);
    check("t1_pend_set", 64'(pending_any), 64'd1);
    check("t1_not_yet",  64'(msg_valid), 64'd0);
    tick();
    check("t1_valid", 64'(msg_valid), 64'd1);
    check("t1_addr",  msg_addr, 64'h0000_0000_FEE0_1000);
    check("t1_data",  64'(msg_data), 64'h42);
    check("t1_vec",   64'(msg_vector), 64'd2);
    check("t1_is64",  64'(msg_is_64bit), 64'd0);
    tick();
    check("t1_drop", 64'(msg_valid), 64'd0);
    cfg_read("t1_pba", 32, 32'h0);

    // 64-bit address on vector 5
    cfg_write(20, 32'h1000); cfg_write(21, 32'h1);
    cfg_write(22, 32'h55);   cfg_write(23, 0);
    pulse_irq(8'h20);
    tick();
    check("t2_addr", msg_addr, 64'h0000_0001_0000_1000);
    check("t2_is64", 64'(msg_is_64bit), 64'd1);
    check("t2_vec",  64'(msg_vector), 64'd5);
    tick();

    // Masked vector 3, then unmask
    cfg_write(12, 32'hFEE0_0000); cfg_write(13, 0);
    cfg_write(14, 32'h33);        cfg_write(15, 1);
    pulse_irq(8'h08);
    repeat (3) tick();
    check("t3_masked", 64'(msg_valid), 64'd0);
    cfg_read("t3_pba", 32, 32'h8);
    cfg_write(15, 0);
    wait_valid("t3_unmask_wait", 2);
    check("t3_vec", 64'(msg_vector), 64'd3);
    tick();
    cfg_read("t3_pba_clr", 32, 32'h0);

    // Round-robin order
    cfg_write(0, 32'hFEE0_0000);  cfg_write(2, 32'h10); cfg_write(3, 0);
    cfg_write(4, 32'hFEE0_0004);  cfg_write(6, 32'h11); cfg_write(7, 0);
    cfg_write(28, 32'hFEE0_001C); cfg_write(30, 32'h17); cfg_write(31, 0);
    pulse_irq(8'h80);
    repeat (4) tick();
    hs_q.delete();
    pulse_irq(8'h83);
    repeat (10) tick();
    check("t4_count", 64'(hs_q.size()), 64'd3);
    check("t4_o0", 64'(hs_at(0)), 64'd0);
    check("t4_o1", 64'(hs_at(1)), 64'd1);
    check("t4_o2", 64'(hs_at(2)), 64'd7);
    hs_q.delete();
    pulse_irq(8'h81);
    repeat (8) tick();
    check("t4_wrap_count", 64'(hs_q.size()), 64'd2);
    check("t4_wrap_o0", 64'(hs_at(0)), 64'd0);
    check("t4_wrap_o1", 64'(hs_at(1)), 64'd7);

    // Backpressure with rewrite and function mask
    msg_ready = 0;
    cfg_write(16, 32'hFEE0_2000); cfg_write(17, 0);
    cfg_write(18, 32'h44);        cfg_write(19, 0);
    pulse_irq(8'h10);
    tick();
    check("t5_valid", 64'(msg_valid), 64'd1);
    hs_q.delete();
    function_mask = 1;
    for (int i = 0; i < 5; i++) begin
      if (i == 0)      cfg_write(18, 32'h99);
      else if (i == 2) pulse_irq(8'h04);
      else             tick();
      check("t5_hold_valid", 64'(msg_valid), 64'd1);
      check("t5_hold_data",  64'(msg_data), 64'h44);
      check("t5_hold_addr",  msg_addr, 64'h0000_0000_FEE0_2000);
      check("t5_hold_vec",   64'(msg_vector), 64'd4);
    end
    msg_ready = 1;
    tick();
    check("t5_accepted", 64'(hs_at(0)), 64'd4);
    repeat (6) tick();
    check("t5_fm_quiet", 64'(msg_valid), 64'd0);
    check("t5_fm_pend",  64'(pending_any), 64'd1);
    check("t5_one_msg",  64'(hs_q.size()), 64'd1);
    cfg_read("t5_newdata", 18, 32'h99);

    // Reset in the middle of SEND
    msg_ready = 0; function_mask = 0;
    wait_valid("t6_wait", 3);
    rst_n = 0; msg_ready = 1;
    tick();
    check("t6_valid", 64'(msg_valid), 64'd0);
    check("t6_pend",  64'(pending_any), 64'd0);
    rst_n = 1; msg_ready = 0;
    for (int e = 0; e < NV; e++) cfg_read("t6_mask", 4*e + 3, 32'h1);
    cfg_read("t6_oor",   4*NV + 40, 32'h0);
    cfg_read("t6_lower", 8, 32'h0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
